// File: rtl/multiplicador_sequencial_pkg.sv
// Shared definitions for the sequential multiplier and the step decoder that drives it.
package multiplicador_sequencial_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CALCULA = 2'b01,
    PRONTO  = 2'b10
  } estado_t;

  localparam int LARGURA_PADRAO = 8;

  // Opcode the decoder uses to launch a multiplication.
  localparam logic [2:0] REG_OP_MULT = 3'b010;

  // One extra bit so the counter can represent LARGURA itself.
  function automatic int largura_iter(input int largura);
    return $clog2(largura) + 1;
  endfunction

  localparam int ITER_W_PADRAO = largura_iter(LARGURA_PADRAO);

endpackage

// File: rtl/multiplicador_sequencial.sv
// Shift-and-add unsigned multiplier with fixed LARGURA-cycle latency and a held ready level.
//
// state   | meaning
// OCIOSO  | idle, waiting for StartMult
// CALCULA | one shift-and-add iteration per cycle
// PRONTO  | Produto valid and held; StartMult restarts
module multiplicador_sequencial
  import multiplicador_sequencial_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   StartMult,
  input  logic [LARGURA-1:0]     OperandoA,
  input  logic [LARGURA-1:0]     OperandoB,
  output logic [2*LARGURA-1:0]   Produto,
  output logic                   ProntoMult,
  output logic                   Ocupado,
  output logic                   Overflow,
  output logic                   Zero
);

  localparam int ITER_W = largura_iter(LARGURA);
  localparam logic [ITER_W-1:0] ITER_ULTIMA = ITER_W'(LARGURA - 1);

  estado_t                estado, estado_prox;
  logic [2*LARGURA-1:0]   mcand;
  logic [2*LARGURA-1:0]   acc;
  logic [2*LARGURA-1:0]   acc_prox;
  logic [LARGURA-1:0]     mplier;
  logic [ITER_W-1:0]      iter;
  logic                   ultima;
  logic                   aceita_start;

  assign ultima       = (iter == ITER_ULTIMA);
  assign aceita_start = StartMult && (estado == OCIOSO || estado == PRONTO);
  assign acc_prox     = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge Clock) begin
    if (Reset) estado <= OCIOSO;
    else       estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO:  if (StartMult) estado_prox = CALCULA;
      CALCULA: if (ultima)    estado_prox = PRONTO;
      PRONTO:  if (StartMult) estado_prox = CALCULA;
      default:                estado_prox = OCIOSO;
    endcase
  end

  always_comb begin
    Ocupado    = 1'b0;
    ProntoMult = 1'b0;
    case (estado)
      CALCULA: Ocupado    = 1'b1;
      PRONTO:  ProntoMult = 1'b1;
      default: ;
    endcase
  end

  // No early exit: the iteration count is fixed so the decoder wait stays bounded.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      iter    <= '0;
      Produto <= '0;
    end else if (aceita_start) begin
      mcand   <= {{LARGURA{1'b0}}, OperandoA};
      mplier  <= OperandoB;
      acc     <= '0;
      iter    <= '0;
    end else if (estado == CALCULA) begin
      acc    <= acc_prox;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      iter   <= iter + 1'b1;
      if (ultima) Produto <= acc_prox;
    end
  end

  assign Overflow = |Produto[2*LARGURA-1:LARGURA];
  assign Zero     = (Produto == '0);

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Directed bench for multiplicador_sequencial: cycle-level behavioural model plus literal checks.
module tb_multiplicador_sequencial;

  localparam int L = 8;

  logic           Clock;
  logic           Reset;
  logic           StartMult;
  logic [L-1:0]   OperandoA;
  logic [L-1:0]   OperandoB;
  logic [2*L-1:0] Produto;
  logic           ProntoMult;
  logic           Ocupado;
  logic           Overflow;
  logic           Zero;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  multiplicador_sequencial #(.LARGURA(L)) dut (
    .Clock(Clock), .Reset(Reset), .StartMult(StartMult),
    .OperandoA(OperandoA), .OperandoB(OperandoB),
    .Produto(Produto), .ProntoMult(ProntoMult), .Ocupado(Ocupado),
    .Overflow(Overflow), .Zero(Zero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a start accepted when not busy yields A*B after exactly L further edges.
  int             m_cnt = 0;
  logic           m_busy = 1'b0;
  logic           m_pronto = 1'b0;
  logic [2*L-1:0] m_prod = '0;
  logic [2*L-1:0] m_pend = '0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_busy = 1'b0; m_pronto = 1'b0; m_prod = '0; m_cnt = 0;
    end else if (m_busy) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy = 1'b0; m_pronto = 1'b1; m_prod = m_pend;
      end
    end else if (StartMult) begin
      m_busy = 1'b1; m_pronto = 1'b0; m_cnt = L;
      m_pend = (2*L)'(OperandoA) * (2*L)'(OperandoB);
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      check("model_produto",  32'(Produto),    32'(m_prod));
      check("model_pronto",   32'(ProntoMult), 32'(m_pronto));
      check("model_ocupado",  32'(Ocupado),    32'(m_busy));
      check("model_overflow", 32'(Overflow),   32'(m_prod > 16'd255));
      check("model_zero",     32'(Zero),       32'(m_prod == 16'd0));
    end
  end

  // Called at a negedge; the start is sampled on the next posedge. Returns at the negedge after it.
  task automatic pulse_start(input logic [L-1:0] a, input logic [L-1:0] b);
    OperandoA = a; OperandoB = b; StartMult = 1'b1;
    @(negedge Clock);
    StartMult = 1'b0; OperandoA = 8'hA5; OperandoB = 8'h5A;
  endtask

  task automatic run_mult(input logic [L-1:0] a, input logic [L-1:0] b,
                          input logic [2*L-1:0] exp, input string tag);
    pulse_start(a, b);
    check({tag, "_ocupado_k"}, 32'(Ocupado), 32'd1);
    repeat (L-1) @(negedge Clock);
    check({tag, "_pronto_early"}, 32'(ProntoMult), 32'd0);
    @(negedge Clock);
    check({tag, "_pronto"}, 32'(ProntoMult), 32'd1);
    check({tag, "_produto"}, 32'(Produto), 32'(exp));
  endtask

  initial begin
    Reset = 1'b1; StartMult = 1'b0; OperandoA = '0; OperandoB = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    chk_en = 1'b1;
    check("rst_produto", 32'(Produto), 32'd0);
    check("rst_pronto",  32'(ProntoMult), 32'd0);
    check("rst_zero",    32'(Zero), 32'd1);
    @(negedge Clock);

    run_mult(8'd13, 8'd11, 16'd143, "basic");
    check("basic_ovf",  32'(Overflow), 32'd0);
    check("basic_zero", 32'(Zero), 32'd0);
    repeat (20) @(negedge Clock);
    check("basic_hold", 32'(ProntoMult), 32'd1);

    run_mult(8'd255, 8'd255, 16'd65025, "max");
    check("max_ovf", 32'(Overflow), 32'd1);

    run_mult(8'd0, 8'd200, 16'd0, "zero");
    check("zero_flag", 32'(Zero), 32'd1);
    @(negedge Clock);

    // Start while busy: the second pulse lands on the third iteration edge.
    pulse_start(8'd7, 8'd9);
    repeat (2) @(negedge Clock);
    pulse_start(8'd100, 8'd100);
    repeat (4) @(negedge Clock);
    check("busy_pronto_early", 32'(ProntoMult), 32'd0);
    @(negedge Clock);
    check("busy_pronto",  32'(ProntoMult), 32'd1);
    check("busy_produto", 32'(Produto), 32'd63);

    // Reset mid-operation, asserted for the fourth iteration edge.
    pulse_start(8'd50, 8'd50);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_produto", 32'(Produto), 32'd0);
    check("abort_pronto",  32'(ProntoMult), 32'd0);
    check("abort_ocupado", 32'(Ocupado), 32'd0);
    check("abort_zero",    32'(Zero), 32'd1);
    repeat (10) @(negedge Clock);
    check("abort_no_pronto", 32'(ProntoMult), 32'd0);
    run_mult(8'd3, 8'd4, 16'd12, "after_abort");

    // Restart from PRONTO.
    @(negedge Clock);
    run_mult(8'd13, 8'd11, 16'd143, "hold");
    repeat (5) @(negedge Clock);
    pulse_start(8'd16, 8'd16);
    check("restart_pronto_drop", 32'(ProntoMult), 32'd0);
    check("restart_keep_prod",   32'(Produto), 32'd143);
    repeat (L-1) @(negedge Clock);
    check("restart_keep_late", 32'(Produto), 32'd143);
    @(negedge Clock);
    check("restart_produto", 32'(Produto), 32'd256);
    check("restart_ovf",     32'(Overflow), 32'd1);

    // Back-to-back start on the first PRONTO cycle.
    run_mult(8'd2, 8'd3, 16'd6, "b2b");

    // Reset wins over a simultaneous start.
    Reset = 1'b1; StartMult = 1'b1; OperandoA = 8'd9; OperandoB = 8'd9;
    @(negedge Clock);
    Reset = 1'b0; StartMult = 1'b0;
    check("rst_prio_ocupado", 32'(Ocupado), 32'd0);
    check("rst_prio_produto", 32'(Produto), 32'd0);
    repeat (3) @(negedge Clock);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplicador_sequencial.md
# multiplicador_sequencial

Sequential shift-and-add unsigned multiplier for the RPN ALU datapath. It sits directly downstream of the step decoder. It consumes `StartMult` together with the registered A/B operands, and returns `ProntoMult` plus a 16-bit product. The result multiplexer selects this product when `SelResultado`=1. Latency is fixed and deterministic, so the decoder's wait logic (`AguardandoMult`) is bounded.

## Interface
- `LARGURA`, default 8: operand width; the product is 2·`LARGURA` bits wide.
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- `StartMult`  in  1  start request; a single-cycle pulse from the decoder.
- `OperandoA`  in  `LARGURA`  multiplicand; sampled only on an accepted start.
- `OperandoB`  in  `LARGURA`  multiplier; sampled only on an accepted start.
- `Produto`  out  2·`LARGURA`  last completed product, registered.
- `ProntoMult`  out  1  level signal: the product is valid and held.
- `Ocupado`  out  1  high while iterating.
- `Overflow`  out  1  `Produto[15:8]` ≠ 0, i.e. the product does not fit the 8-bit display/ALU path.
- `Zero`  out  1  `Produto` = 0.

## Operation
- States are `OCIOSO`, `CALCULA` and `PRONTO`.
- **`OCIOSO`:**
  - `StartMult`=1 loads the internal registers: `mcand` ← zero-extended `OperandoA`, `mplier` ← `OperandoB`, `acc` ← 0, `iter` ← 0.
  - The block then goes to `CALCULA`.
- **`CALCULA`:** each cycle performs one iteration.
  - If `mplier[0]`=1: `acc` ← `acc` + `mcand` (the sum is 16 bits wide and cannot overflow).
  - `mcand` ← `mcand` << 1, `mplier` ← `mplier` >> 1, `iter` ← `iter` + 1.
  - There is always exactly `LARGURA` iterations; there is no early exit when `mplier` reaches 0.
  - On the final iteration, `Produto` ← final `acc` value and the block goes to `PRONTO`.
- **`PRONTO`:**
  - `ProntoMult`=1 is held indefinitely. The decoder relies on this level to keep `Resultado` asserted and to release `AguardandoMult`; a pulse would deadlock it.
  - `StartMult`=1 restarts with the same load as in `OCIOSO` and returns to `CALCULA`.
- **`StartMult` during `CALCULA`:** ignored. Operands are not resampled and the iteration count is unaffected.
- **Operand changes:** changes on `OperandoA`/`OperandoB` outside an accepted start edge have no effect.
- **`Produto`:** changes only on entry to `PRONTO` or on `Reset`. It holds the previous product throughout `CALCULA`.
- **Flags:** `Overflow` and `Zero` are combinational from the `Produto` register.
- **`Ocupado`** = (state == `CALCULA`). **`ProntoMult`** = (state == `PRONTO`). The two are never high together.
- **Reset:**
  - All outputs reset to: `Produto`=0, `ProntoMult`=0, `Ocupado`=0, `Overflow`=0, `Zero`=1.
  - The state returns to `OCIOSO`.
  - Reset has priority over `StartMult` in the same cycle.
  - Reset mid-`CALCULA` aborts the operation and produces no `ProntoMult`.

## Timing
- With the start sampled at edge k:
  - `Ocupado`=1 from after edge k.
  - Iterations run on edges k+1 … k+`LARGURA`.
  - `ProntoMult`=1 and the new `Produto` are visible after edge k+`LARGURA` (8 cycles for the default width).
- A restart accepted in `PRONTO` at edge k drops `ProntoMult` after edge k. `Produto` keeps its old value until edge k+8.
- A back-to-back start is possible on the first cycle of `PRONTO`.

## Structure
- Shared package contents:
  - state encodings `OCIOSO`/`CALCULA`/`PRONTO` (2-bit);
  - default `LARGURA`=8;
  - iteration counter width = clog2(`LARGURA`)+1.
- The RTP opcode constant for multiplication (`RegOp`=3'b010) also belongs in the same package, shared with the decoder.
- No sub-module is needed. The FSM, the shift registers, the adder and the counter sit in one module, roughly 150 lines.

## Test plan
- **Basic product:** reset, then `OperandoA`=13, `OperandoB`=11, `StartMult` pulse → `Ocupado` for 8 cycles, then `ProntoMult`=1, `Produto`=143, `Overflow`=0, `Zero`=0. `ProntoMult` is held for ≥20 idle cycles.
- **Maximum operands:** 255×255 → `Produto`=65025, `Overflow`=1, exactly 8 cycles after the start edge.
- **Zero operand:** 0×200 → `Produto`=0, `Zero`=1. Latency is still 8 cycles.
- **Start while busy:** start 7×9; at iteration 3, pulse `StartMult` with A=100, B=100 → ignored; `Produto`=63 at the normal time.
- **Reset mid-operation:** start 50×50; assert `Reset` at iteration 4 → after that edge all outputs are at reset values and the state is `OCIOSO`. `ProntoMult` never rises. A subsequent 3×4 gives 12.
- **Restart from `PRONTO`:** hold `PRONTO` with 143, then start 16×16 → `ProntoMult`=0 the next cycle and `Produto` stays 143 during iteration. After 8 cycles, `Produto`=256, `Overflow`=1.
